// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package rv_fetch_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } fetch_state_t;

   localparam int          ILEN             = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   function automatic logic is_misaligned(input logic [ILEN-1:0] i_addr);
      return i_addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order FIFO with synchronous flush; used for the instruction buffer
// and for the queue of issued fetch addresses.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] i_ptr);
      return (i_ptr == AW'(DEPTH - 1)) ? '0 : i_ptr + AW'(1);
   endfunction

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rd_ptr];
   // A push into a full FIFO is accepted only when the head leaves the same cycle.
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues word requests to instruction memory and
// buffers returned words with their PCs for decode; redirects flush and restart.
module instruction_fetch
   import rv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instruction,
   output logic [31:0] instr_pc,
   output logic        misaligned
);

   localparam int          CW    = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW:0] LIMIT = FIFO_DEPTH[CW:0];

   fetch_state_t      r_state;
   logic [ILEN-1:0]   r_fetch_pc;
   logic [CW-1:0]     r_discard;

   logic              w_run;
   logic              w_grant;
   logic              w_resp;
   logic              w_redir;
   logic              w_push;
   logic              w_pop;
   logic [CW:0]       w_inflight;
   logic [CW-1:0]     w_out_next;

   logic [2*ILEN-1:0] w_buf_din;
   logic [2*ILEN-1:0] w_buf_dout;
   logic              w_buf_full;
   logic              w_buf_empty;
   logic [CW-1:0]     w_buf_count;

   logic [ILEN-1:0]   w_tag_pc;
   logic              w_tag_full;
   logic              w_tag_empty;
   logic [CW-1:0]     w_outstanding;

   // The tag queue holds one PC per granted request, so its occupancy is the outstanding count.
   assign w_run      = (r_state == RUN);
   assign w_inflight = {1'b0, w_outstanding} + {1'b0, w_buf_count};
   assign imem_req   = !rst && w_run && !w_tag_full && !w_buf_full && (w_inflight < LIMIT);
   assign imem_addr  = r_fetch_pc;
   assign w_grant    = imem_req && imem_gnt;
   assign w_resp     = imem_rvalid && !w_tag_empty;
   assign w_redir    = redirect && w_run;
   assign w_out_next = w_outstanding + CW'(w_grant) - CW'(w_resp);
   assign w_push     = w_resp && w_run && (r_discard == '0) && !w_redir;
   assign w_pop      = instr_valid && instr_ready && !w_redir;
   assign w_buf_din  = {w_tag_pc, imem_rdata};

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ILEN)
   ) u_tag_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_grant),
      .i_pop   (w_resp),
      .i_flush (1'b0),
      .i_data  (r_fetch_pc),
      .o_data  (w_tag_pc),
      .o_full  (w_tag_full),
      .o_empty (w_tag_empty),
      .o_count (w_outstanding)
   );

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (2 * ILEN)
   ) u_buf_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_redir),
      .i_data  (w_buf_din),
      .o_data  (w_buf_dout),
      .o_full  (w_buf_full),
      .o_empty (w_buf_empty),
      .o_count (w_buf_count)
   );

   // Words still in flight at a redirect (including one granted that cycle) are counted off and dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= RUN;
         r_fetch_pc <= RESET_PC;
         r_discard  <= '0;
      end else if (w_redir) begin
         r_fetch_pc <= redirect_target;
         r_discard  <= w_out_next;
         if (is_misaligned(redirect_target)) r_state <= FAULT;
      end else begin
         if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
         if (w_resp && (r_discard != '0)) r_discard <= r_discard - CW'(1);
      end
   end

   assign instr_valid = w_run && !w_buf_empty;
   assign instruction = instr_valid ? w_buf_dout[ILEN-1:0]      : '0;
   assign instr_pc    = instr_valid ? w_buf_dout[2*ILEN-1:ILEN] : '0;
   assign misaligned  = (r_state == FAULT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch with an in-order memory model and an
// expected-PC stream model of what decode must see.
module tb_instruction_fetch;

   localparam int          DEPTH = 2;
   localparam logic [31:0] RPC   = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instruction;
   logic [31:0] instr_pc;
   logic        misaligned;

   always #5 clk = ~clk;

   instruction_fetch #(
      .RESET_PC   (RPC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_gnt        (imem_gnt),
      .imem_rvalid     (imem_rvalid),
      .imem_rdata      (imem_rdata),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instruction     (instruction),
      .instr_pc        (instr_pc),
      .misaligned      (misaligned)
   );

   int checks = 0;
   int errors = 0;

   // Memory model: in-order queue of granted addresses and the cycle each may respond.
   logic [31:0] q_addr[$];
   int          q_due[$];
   logic [31:0] m_fetch;
   logic [31:0] exp_pc;
   logic [31:0] last_redir;
   bit          m_fault;
   bit          redir_prev;
   int          cyc;
   int          max_lat;
   int          n_xfer;
   int          n_gnt;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic drive(input int p_gnt, input int p_rv, input int p_rdy);
      imem_gnt    = ($urandom_range(0, 99) < p_gnt);
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (q_addr.size() != 0 && q_due[0] <= cyc && $urandom_range(0, 99) < p_rv) begin
         imem_rvalid = 1'b1;
         imem_rdata  = q_addr[0] + 32'h13;
      end
      instr_ready     = ($urandom_range(0, 99) < p_rdy);
      redirect        = 1'b0;
      redirect_target = '0;
   endtask

   task automatic step();
      #1;
      if (redir_prev) begin
         check_val("redir_valid", instr_valid, 0);
         if (!m_fault) check_val("redir_addr", imem_addr, last_redir);
      end
      if (m_fault) begin
         check_val("flt_req", imem_req, 0);
         check_val("flt_valid", instr_valid, 0);
         check_val("flt_mis", misaligned, 1);
      end
      if (imem_req && imem_gnt) begin
         check_val("addr", imem_addr, m_fetch);
         q_addr.push_back(imem_addr);
         q_due.push_back(cyc + 1 + $urandom_range(0, max_lat));
         check_val("outst_bound", q_addr.size() <= DEPTH, 1);
         m_fetch = m_fetch + 32'd4;
         n_gnt++;
      end
      if (imem_rvalid) begin
         void'(q_addr.pop_front());
         void'(q_due.pop_front());
      end
      redir_prev = 1'b0;
      if (redirect) begin
         last_redir = redirect_target;
         redir_prev = 1'b1;
         if (redirect_target[1:0] != 2'b00) m_fault = 1'b1;
         else begin
            m_fetch = redirect_target;
            exp_pc  = redirect_target;
         end
      end else if (instr_valid && instr_ready && !m_fault) begin
         check_val("pc", instr_pc, exp_pc);
         check_val("instr", instruction, exp_pc + 32'h13);
         exp_pc = exp_pc + 32'd4;
         n_xfer++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic model_reset();
      q_addr.delete();
      q_due.delete();
      m_fetch    = RPC;
      exp_pc     = RPC;
      m_fault    = 1'b0;
      redir_prev = 1'b0;
   endtask

   task automatic check_reset_outputs();
      check_val("rst_req", imem_req, 0);
      check_val("rst_addr", imem_addr, RPC);
      check_val("rst_valid", instr_valid, 0);
      check_val("rst_instr", instruction, 0);
      check_val("rst_pc", instr_pc, 0);
      check_val("rst_mis", misaligned, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] tgt;
      int          g0;
      int          k;
      cyc    = 0;
      n_xfer = 0;
      n_gnt  = 0;
      max_lat = 0;
      model_reset();
      rst = 1'b1;
      drive(0, 0, 0);
      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst = 1'b0;
      #1;
      check_val("first_req", imem_req, 1);
      check_val("first_addr", imem_addr, RPC);

      // Zero-wait memory, decode always ready.
      repeat (20) begin
         drive(100, 100, 100);
         step();
      end

      // Decode stalls: buffered head holds, requests stop once the buffer is full.
      g0 = n_gnt;
      repeat (10) begin
         drive(100, 100, 0);
         step();
         if (instr_valid) begin
            check_val("hold_pc", instr_pc, exp_pc);
            check_val("hold_instr", instruction, exp_pc + 32'h13);
         end
      end
      check_val("stall_req", imem_req, 0);
      check_val("stall_gnts", (n_gnt - g0) <= DEPTH, 1);
      repeat (10) begin
         drive(100, 100, 100);
         step();
      end

      // Redirect with two requests outstanding.
      k = 0;
      while (q_addr.size() < 2 && k < 20) begin
         drive(100, 0, 100);
         step();
         k++;
      end
      check_val("two_outstanding", q_addr.size(), 2);
      drive(0, 0, 100);
      redirect        = 1'b1;
      redirect_target = 32'h0000_0100;
      step();
      max_lat = 2;
      repeat (30) begin
         drive(80, 80, 100);
         step();
      end

      // Redirect in the same cycle as a grant and a response.
      for (int i = 0; i < 40; i++) begin
         drive(100, 100, 50);
         if (imem_rvalid && imem_req) begin
            redirect        = 1'b1;
            redirect_target = 32'h0000_0200;
            step();
            break;
         end
         step();
      end
      check_val("same_cycle_redir", last_redir, 32'h0000_0200);
      repeat (30) begin
         drive(80, 80, 80);
         step();
      end

      // Random traffic with occasional aligned redirects.
      repeat (400) begin
         drive(70, 70, 70);
         if ($urandom_range(0, 99) < 3) begin
            tgt             = $urandom;
            tgt[1:0]        = 2'b00;
            redirect        = 1'b1;
            redirect_target = tgt;
         end
         step();
      end

      // Address wrap at the top of the space.
      max_lat = 0;
      drive(100, 100, 100);
      redirect        = 1'b1;
      redirect_target = 32'hFFFF_FFFC;
      step();
      repeat (12) begin
         drive(100, 100, 100);
         step();
      end
      check_val("wrap_reached", exp_pc < 32'h0000_0100, 1);

      // Misaligned redirect is sticky until reset.
      drive(100, 100, 100);
      redirect        = 1'b1;
      redirect_target = 32'h0000_0102;
      step();
      repeat (10) begin
         drive(100, 100, 100);
         step();
      end

      // Reset in the middle of operation.
      rst = 1'b1;
      #1;
      model_reset();
      check_reset_outputs();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_val("rerun_req", imem_req, 1);
      check_val("rerun_addr", imem_addr, RPC);
      max_lat = 1;
      repeat (30) begin
         drive(90, 90, 90);
         step();
      end
      check_val("progress", n_xfer > 100, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
